testport_reporter: RTL

Result-reporting transmitter for the MultDiv extension test flow. It drives the simulation test port as a write master:
- one begin-symbol write;
- a fixed number of result words taken from a valid/ready source;
- one end-symbol write.

It paces writes so that every write is followed by at least one `wen`-low cycle, and holds a write while the data-memory path stalls. It sits between the core's result source (for example the MultDiv unit or a store-snoop path) and the memory-side `addr`/`data`/`wen` bus watched by the checker.

---
 rtl/testport_pkg.sv | 23 ++
 rtl/testport_reporter.sv | 119 +++++++++++
 2 files changed

// File: rtl/testport_pkg.sv
// Shared constants and state type for the test-port result reporter.
package testport_pkg;

    localparam logic [29:0] TEST_PORT    = 30'hFF;
    localparam logic [31:0] BEGIN_SYMBOL = 32'h0000_0168;
    localparam logic [31:0] END_SYMBOL   = 32'h0000_0D5D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_BEGIN,
        ST_WAIT_RES,
        ST_WR_DATA,
        ST_GAP,
        ST_WR_SUM,
        ST_WR_END,
        ST_DONE
    } state_t;

    function automatic logic is_write(input state_t s);
        return s inside {ST_WR_BEGIN, ST_WR_DATA, ST_WR_SUM, ST_WR_END};
    endfunction

endpackage

// File: rtl/testport_reporter.sv
// Test-port write master: begin symbol, NUM_RESULTS result words, end symbol.
// Optional TESTPORT_CHECKSUM_EN appends an XOR checksum write before the end symbol.
module testport_reporter
    import testport_pkg::*;
#(
    parameter int unsigned NUM_RESULTS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic        res_valid,
    input  logic [31:0] res_data,
    output logic        res_ready,
    output logic [29:0] addr,
    output logic [31:0] data,
    output logic        wen,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] NUM_RES = 8'(NUM_RESULTS);

    state_t      state, nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [31:0] data_nxt;

`ifdef TESTPORT_CHECKSUM_EN
    logic [31:0] csum;
    logic        sum_sent;
    logic        accept;

    assign accept = (state == ST_WAIT_RES) && res_valid;
`endif

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    nxt     = ST_WR_BEGIN;
                    cnt_nxt = '0;
                end
            end
            ST_WR_BEGIN: if (!stall) nxt = ST_WAIT_RES;
            ST_WAIT_RES: if (res_valid) nxt = ST_WR_DATA;
            ST_WR_DATA: begin
                if (!stall) begin
                    cnt_nxt = cnt + 8'd1;
                    nxt     = (cnt_nxt == NUM_RES) ? ST_GAP : ST_WAIT_RES;
                end
            end
`ifdef TESTPORT_CHECKSUM_EN
            // GAP is visited twice: before the checksum write and after it.
            ST_GAP:      nxt = sum_sent ? ST_WR_END : ST_WR_SUM;
            ST_WR_SUM:   if (!stall) nxt = ST_GAP;
`else
            ST_GAP:      nxt = ST_WR_END;
`endif
            ST_WR_END:   if (!stall) nxt = ST_DONE;
            default:     nxt = ST_IDLE;
        endcase
    end

    // Data only changes on entry to a write state, so a stalled write stays bit-identical.
    always_comb begin
        data_nxt = data;
        if (nxt != state) begin
            case (nxt)
                ST_WR_BEGIN: data_nxt = BEGIN_SYMBOL;
                ST_WR_DATA:  data_nxt = res_data;
`ifdef TESTPORT_CHECKSUM_EN
                ST_WR_SUM:   data_nxt = csum;
`endif
                ST_WR_END:   data_nxt = END_SYMBOL;
                default:     data_nxt = data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            addr      <= '0;
            data      <= '0;
            wen       <= 1'b0;
            res_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= cnt_nxt;
            addr      <= TEST_PORT;
            data      <= data_nxt;
            wen       <= is_write(nxt);
            res_ready <= (nxt == ST_WAIT_RES);
            busy      <= !((nxt == ST_IDLE) || (nxt == ST_DONE));
            done      <= (nxt == ST_DONE);
        end
    end

`ifdef TESTPORT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            csum     <= '0;
            sum_sent <= 1'b0;
        end else if (((state == ST_IDLE) || (state == ST_DONE)) && start) begin
            csum     <= '0;
            sum_sent <= 1'b0;
        end else begin
            if (accept) csum <= csum ^ res_data;
            if ((state == ST_WR_SUM) && !stall) sum_sent <= 1'b1;
        end
    end
`endif

endmodule
